tawas_regfile: RTL

Dual-slice register file for the Tawas core, sitting on both sides of the arithmetic unit: it supplies the AU's A/B operands and the load/store read operand, and it absorbs AU write-back and load-data write-back. It holds two banks of eight 32-bit registers, one bank per SLICE thread. Each bank has a single physical write port. Load write-backs that collide with an AU write are held in a small per-bank pending queue, and reads forward from that queue.

---
 rtl/tawas_regfile.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/tawas_regfile.sv
// Tawas dual-slice register file: two banks of eight 32-bit registers. Load
// write-backs that lose the bank write port to the AU wait in a per-bank queue.
module tawas_regfile #(
    parameter int PEND_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        SLICE,
    input  logic [2:0]  AU_RA_SEL,
    output logic [31:0] AU_RA,
    input  logic [2:0]  AU_RB_SEL,
    output logic [31:0] AU_RB,
    input  logic        AU_RC_VLD,
    input  logic [2:0]  AU_RC_SEL,
    input  logic [31:0] AU_RC,
    input  logic [2:0]  LS_RD_SEL,
    output logic [31:0] LS_RD,
    input  logic        LS_RC_VLD,
    input  logic        LS_RC_SLICE,
    input  logic [2:0]  LS_RC_SEL,
    input  logic [31:0] LS_RC,
    output logic        LS_RC_RDY
);
    localparam int unsigned DEPTH = PEND_DEPTH;
    localparam int unsigned CW    = $clog2(DEPTH + 1);

    logic [31:0]   regs    [2][8];
    logic          q_vld   [2][DEPTH];
    logic [2:0]    q_sel   [2][DEPTH];
    logic [31:0]   q_dat   [2][DEPTH];
    logic [CW-1:0] q_cnt   [2];

    logic          q_vld_n [2][DEPTH];
    logic [2:0]    q_sel_n [2][DEPTH];
    logic [31:0]   q_dat_n [2][DEPTH];
    logic [CW-1:0] q_cnt_n [2];
    logic [CW-1:0] tail    [2];
    logic          wr_en   [2];
    logic [2:0]    wr_sel  [2];
    logic [31:0]   wr_dat  [2];
    logic          bank_au [2];
    logic          bank_ls [2];
    logic          pop     [2];
    logic          direct  [2];
    logic          push    [2];

    assign LS_RC_RDY = (q_cnt[0] < CW'(DEPTH)) && (q_cnt[1] < CW'(DEPTH));

    always_comb begin
        bank_au[0] = AU_RC_VLD &  SLICE;
        bank_au[1] = AU_RC_VLD & ~SLICE;
        bank_ls[0] = LS_RC_VLD & LS_RC_RDY & ~LS_RC_SLICE;
        bank_ls[1] = LS_RC_VLD & LS_RC_RDY &  LS_RC_SLICE;
        for (int unsigned b = 0; b < 2; b++) begin
            pop[b]     = !bank_au[b] && (q_cnt[b] != '0);
            direct[b]  = bank_ls[b] && !bank_au[b] && (q_cnt[b] == '0);
            push[b]    = bank_ls[b] && !direct[b];
            tail[b]    = q_cnt[b] - CW'(pop[b]);
            q_cnt_n[b] = tail[b] + CW'(push[b]);

            // One array write per bank: AU, then queue drain, then direct load.
            wr_en[b]  = 1'b0;
            wr_sel[b] = '0;
            wr_dat[b] = '0;
            if (bank_au[b]) begin
                wr_en[b]  = 1'b1;
                wr_sel[b] = AU_RC_SEL;
                wr_dat[b] = AU_RC;
            end else if (pop[b]) begin
                wr_en[b]  = q_vld[b][0];
                wr_sel[b] = q_sel[b][0];
                wr_dat[b] = q_dat[b][0];
            end else if (direct[b]) begin
                wr_en[b]  = 1'b1;
                wr_sel[b] = LS_RC_SEL;
                wr_dat[b] = LS_RC;
            end

            // Kill is applied to pre-edge entries before the push, so a load
            // pushed alongside a same-index AU write survives.
            for (int unsigned e = 0; e < DEPTH; e++) begin
                int unsigned nxt;
                nxt = (e + 1 < DEPTH) ? e + 1 : e;
                if (pop[b]) begin
                    q_vld_n[b][e] = (e + 1 < DEPTH) && q_vld[b][nxt];
                    q_sel_n[b][e] = q_sel[b][nxt];
                    q_dat_n[b][e] = q_dat[b][nxt];
                end else begin
                    q_vld_n[b][e] = q_vld[b][e] &&
                                    !(bank_au[b] && (q_sel[b][e] == AU_RC_SEL));
                    q_sel_n[b][e] = q_sel[b][e];
                    q_dat_n[b][e] = q_dat[b][e];
                end
                if (push[b] && (CW'(e) == tail[b])) begin
                    q_vld_n[b][e] = 1'b1;
                    q_sel_n[b][e] = LS_RC_SEL;
                    q_dat_n[b][e] = LS_RC;
                end
            end
        end
    end

    // Youngest valid queued entry overrides the array value.
    always_comb begin
        AU_RA = regs[SLICE][AU_RA_SEL];
        AU_RB = regs[SLICE][AU_RB_SEL];
        LS_RD = regs[SLICE][LS_RD_SEL];
        for (int unsigned e = 0; e < DEPTH; e++) begin
            if (q_vld[SLICE][e]) begin
                if (q_sel[SLICE][e] == AU_RA_SEL) AU_RA = q_dat[SLICE][e];
                if (q_sel[SLICE][e] == AU_RB_SEL) AU_RB = q_dat[SLICE][e];
                if (q_sel[SLICE][e] == LS_RD_SEL) LS_RD = q_dat[SLICE][e];
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int unsigned b = 0; b < 2; b++) begin
                q_cnt[b] <= '0;
                for (int unsigned i = 0; i < 8; i++) regs[b][i] <= '0;
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    q_vld[b][e] <= 1'b0;
                    q_sel[b][e] <= '0;
                    q_dat[b][e] <= '0;
                end
            end
        end else begin
            for (int unsigned b = 0; b < 2; b++) begin
                if (wr_en[b]) regs[b][wr_sel[b]] <= wr_dat[b];
                q_cnt[b] <= q_cnt_n[b];
                for (int unsigned e = 0; e < DEPTH; e++) begin
                    q_vld[b][e] <= q_vld_n[b][e];
                    q_sel[b][e] <= q_sel_n[b][e];
                    q_dat[b][e] <= q_dat_n[b][e];
                end
            end
        end
    end

endmodule
